// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches landing calls into per-floor/direction slots and hands each
// pending call to the cheaper of two cars over a registered valid/ready assignment port.
module hall_call_dispatcher #(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  logic [FLOOR_W-1:0]    request_floor,
  input  logic                  request_dir,
  input  logic [1:0]            traffic_state,
  input  logic [FLOOR_W-1:0]    current_floor_elev_1,
  input  logic [FLOOR_W-1:0]    current_floor_elev_2,
  input  logic                  current_dir_elev_1,
  input  logic                  current_dir_elev_2,
  input  logic                  idle_elev_1,
  input  logic                  idle_elev_2,
  input  logic                  arrived_elev_1,
  input  logic                  arrived_elev_2,
  output logic                  assign_valid_1,
  output logic                  assign_valid_2,
  output logic [FLOOR_W-1:0]    assign_floor_1,
  output logic [FLOOR_W-1:0]    assign_floor_2,
  output logic                  assign_dir_1,
  output logic                  assign_dir_2,
  input  logic                  assign_ready_1,
  input  logic                  assign_ready_2,
  output logic [NUM_FLOORS-1:0] up_calls,
  output logic [NUM_FLOORS-1:0] down_calls
);
  localparam int NUM_SLOTS = 2 * NUM_FLOORS;
  localparam int PTR_W     = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {SCAN, EVAL, ISSUE} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0] r_pending, r_assigned;
  logic [NUM_SLOTS-1:0] w_set_mask, w_clr_mask, w_assign_mask;
  logic [PTR_W-1:0]     r_ptr, w_ptr_inc;
  logic [FLOOR_W-1:0]   r_call_floor;
  logic                 r_call_dir;
  logic                 r_lost;
  logic                 r_toggle;
  logic                 r_valid_1, r_valid_2;
  logic [FLOOR_W-1:0]   r_floor_1, r_floor_2;
  logic                 r_dir_1, r_dir_2;
  logic [4:0]           w_cost_1, w_cost_2;
  logic                 w_hit, w_handshake, w_tie, w_pick_2;

  function automatic logic [4:0] calc_cost(
    input logic [FLOOR_W-1:0] call_f,
    input logic               call_d,
    input logic [FLOOR_W-1:0] car_f,
    input logic               car_d,
    input logic               car_idle
  );
    logic [4:0] d;
    logic       ahead;
    d     = (call_f >= car_f) ? 5'(call_f - car_f) : 5'(car_f - call_f);
    ahead = call_d ? (call_f >= car_f) : (call_f <= car_f);
    if (car_idle || ((car_d == call_d) && ahead)) calc_cost = d;
    else                                          calc_cost = d + 5'd8;
  endfunction

  // Floors outside 0..NUM_FLOORS-1 never match the loop, so they drop out naturally.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (request && (request_floor == FLOOR_W'(f))) begin
        if (request_dir && (f != NUM_FLOORS - 1)) w_set_mask[2*f+1] = 1'b1;
        if (!request_dir && (f != 0))             w_set_mask[2*f]   = 1'b1;
      end
      if (arrived_elev_1 && (current_floor_elev_1 == FLOOR_W'(f))) begin
        if (idle_elev_1 || current_dir_elev_1)  w_clr_mask[2*f+1] = 1'b1;
        if (idle_elev_1 || !current_dir_elev_1) w_clr_mask[2*f]   = 1'b1;
      end
      if (arrived_elev_2 && (current_floor_elev_2 == FLOOR_W'(f))) begin
        if (idle_elev_2 || current_dir_elev_2)  w_clr_mask[2*f+1] = 1'b1;
        if (idle_elev_2 || !current_dir_elev_2) w_clr_mask[2*f]   = 1'b1;
      end
    end
  end

  assign w_hit       = r_pending[r_ptr] && !r_assigned[r_ptr];
  assign w_handshake = (r_valid_1 && assign_ready_1) || (r_valid_2 && assign_ready_2);
  assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_SLOTS - 1)) ? '0 : r_ptr + 1'b1;

  always_comb begin
    w_assign_mask = '0;
    if ((r_state == ISSUE) && w_handshake && !r_lost) w_assign_mask[r_ptr] = 1'b1;
  end

  assign w_cost_1 = calc_cost(r_call_floor, r_call_dir, current_floor_elev_1,
                              current_dir_elev_1, idle_elev_1);
  assign w_cost_2 = calc_cost(r_call_floor, r_call_dir, current_floor_elev_2,
                              current_dir_elev_2, idle_elev_2);
  assign w_tie    = (w_cost_1 == w_cost_2);

  always_comb begin
    w_pick_2 = 1'b0;
    if (w_cost_2 < w_cost_1) begin
      w_pick_2 = 1'b1;
    end else if (w_tie) begin
      case (traffic_state)
        2'b01:   w_pick_2 = (current_floor_elev_2 < current_floor_elev_1);
        2'b10:   w_pick_2 = (current_floor_elev_2 > current_floor_elev_1);
        2'b11:   w_pick_2 = r_toggle;
        default: w_pick_2 = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:    if (w_hit) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = ISSUE;
      ISSUE:   if (w_handshake) w_state_nxt = SCAN;
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SCAN;
    else        r_state <= w_state_nxt;
  end

  // r_lost remembers that the in-flight slot was cleared, so the handshake still
  // completes but must not mark the slot assigned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= '0;
      r_assigned   <= '0;
      r_ptr        <= '0;
      r_call_floor <= '0;
      r_call_dir   <= 1'b0;
      r_lost       <= 1'b0;
      r_toggle     <= 1'b0;
      r_valid_1    <= 1'b0;
      r_valid_2    <= 1'b0;
      r_floor_1    <= '0;
      r_floor_2    <= '0;
      r_dir_1      <= 1'b0;
      r_dir_2      <= 1'b0;
    end else begin
      r_pending  <= (r_pending | w_set_mask) & ~w_clr_mask;
      r_assigned <= (r_assigned | w_assign_mask) & ~w_clr_mask;
      case (r_state)
        SCAN: begin
          if (w_hit) begin
            r_call_floor <= FLOOR_W'(r_ptr >> 1);
            r_call_dir   <= r_ptr[0];
            r_lost       <= w_clr_mask[r_ptr];
          end else begin
            r_ptr <= w_ptr_inc;
          end
        end
        EVAL: begin
          r_lost <= r_lost | w_clr_mask[r_ptr];
          if (w_pick_2) begin
            r_valid_2 <= 1'b1;
            r_floor_2 <= r_call_floor;
            r_dir_2   <= r_call_dir;
          end else begin
            r_valid_1 <= 1'b1;
            r_floor_1 <= r_call_floor;
            r_dir_1   <= r_call_dir;
          end
          if (w_tie && (traffic_state == 2'b11)) r_toggle <= ~r_toggle;
        end
        ISSUE: begin
          r_lost <= r_lost | w_clr_mask[r_ptr];
          if (w_handshake) begin
            r_valid_1 <= 1'b0;
            r_valid_2 <= 1'b0;
            r_floor_1 <= '0;
            r_floor_2 <= '0;
            r_dir_1   <= 1'b0;
            r_dir_2   <= 1'b0;
            r_ptr     <= w_ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    up_calls   = '0;
    down_calls = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      up_calls[f]   = r_pending[2*f+1];
      down_calls[f] = r_pending[2*f];
    end
  end

  assign assign_valid_1 = r_valid_1;
  assign assign_valid_2 = r_valid_2;
  assign assign_floor_1 = r_floor_1;
  assign assign_floor_2 = r_floor_2;
  assign assign_dir_1   = r_dir_1;
  assign assign_dir_2   = r_dir_2;
endmodule
